// File: rtl/dmem_block_responder_if.sv
// Block-transfer bus between the dcache controller (master) and the
// main-memory responder (slave).
interface dmem_block_responder_if #(
  parameter int BLOCK_BITS = 128,
  parameter int ADDR_BITS  = 6
);
  logic                  memRen;
  logic                  memWen;
  logic [ADDR_BITS-1:0]  BlockAddr;
  logic [BLOCK_BITS-1:0] memDin;
  logic                  memReadReady;
  logic                  memWriteDone;
  logic [BLOCK_BITS-1:0] memDout;
  logic                  protocolError;

  modport master (
    output memRen, memWen, BlockAddr, memDin,
    input  memReadReady, memWriteDone, memDout, protocolError
  );

  modport slave (
    input  memRen, memWen, BlockAddr, memDin,
    output memReadReady, memWriteDone, memDout, protocolError
  );
endinterface

// File: rtl/dmem_block_responder.sv
// Main-memory responder for dcache block fills and dirty writebacks: accepts a
// held request, waits a fixed latency, then commits and pulses done/ready.
module dmem_block_responder #(
  parameter int    BLOCK_BITS    = 128,
  parameter int    ADDR_BITS     = 6,
  parameter int    READ_LATENCY  = 4,
  parameter int    WRITE_LATENCY = 4,
  parameter string INIT_FILE     = ""
) (
  input logic clock,
  input logic reset,
  dmem_block_responder_if.slave bus
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, R_WAIT, W_WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [BLOCK_BITS-1:0] data_q, data_d;
  logic [BLOCK_BITS-1:0] dout_q, dout_d;
  logic                  rd_pulse_q, rd_pulse_d;
  logic                  wr_pulse_q, wr_pulse_d;
  logic                  perr_q, perr_d;
  logic                  store_we;

  logic [BLOCK_BITS-1:0] store [2**ADDR_BITS];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    dout_d     = dout_q;
    perr_d     = perr_q;
    rd_pulse_d = 1'b0;
    wr_pulse_d = 1'b0;
    store_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.memWen) begin
          // A simultaneous read request loses to the write and is flagged.
          addr_d  = bus.BlockAddr;
          data_d  = bus.memDin;
          cnt_d   = CNT_W'(WRITE_LATENCY - 1);
          state_d = W_WAIT;
          if (bus.memRen) perr_d = 1'b1;
        end else if (bus.memRen) begin
          addr_d  = bus.BlockAddr;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (cnt_q == '0) begin
          dout_d     = store[addr_q];
          rd_pulse_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      W_WAIT: begin
        if (cnt_q == '0) begin
          store_we   = 1'b1;
          wr_pulse_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      dout_q     <= '0;
      rd_pulse_q <= 1'b0;
      wr_pulse_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      dout_q     <= dout_d;
      rd_pulse_q <= rd_pulse_d;
      wr_pulse_q <= wr_pulse_d;
      perr_q     <= perr_d;
    end
  end

  // NOTE: the store is deliberately not reset; reset only blocks a pending commit.
  always_ff @(posedge clock) begin
    if (store_we && !reset) store[addr_q] <= data_q;
  end

  assign bus.memReadReady  = rd_pulse_q;
  assign bus.memWriteDone  = wr_pulse_q;
  assign bus.memDout       = dout_q;
  assign bus.protocolError = perr_q;

endmodule

// File: tb/tb_dmem_block_responder.sv
// Directed bench for dmem_block_responder: latency-4 instance for the main
// scenarios plus a latency-1 instance for the minimum-latency corner.
module tb_dmem_block_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  dmem_block_responder_if #(.BLOCK_BITS(128), .ADDR_BITS(6)) bus ();
  dmem_block_responder_if #(.BLOCK_BITS(128), .ADDR_BITS(6)) bus1 ();

  dmem_block_responder #(.BLOCK_BITS(128), .ADDR_BITS(6),
                         .READ_LATENCY(4), .WRITE_LATENCY(4)) u_dut (
    .clock(clock), .reset(reset), .bus(bus));

  dmem_block_responder #(.BLOCK_BITS(128), .ADDR_BITS(6),
                         .READ_LATENCY(1), .WRITE_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  localparam logic [127:0] V5   = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_00000005;
  localparam logic [127:0] V7   = 128'h77777777_77777777_77777777_00000007;
  localparam logic [127:0] V9   = 128'h99999999_99999999_99999999_00000009;
  localparam logic [127:0] N9   = 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_00000009;
  localparam logic [127:0] DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] WB   = 128'h10101010_10101010_10101010_0000000A;
  localparam logic [127:0] C12  = 128'hC0C0C0C0_C0C0C0C0_C0C0C0C0_0000000C;
  localparam logic [127:0] C1   = 128'hC1C1C1C1_C1C1C1C1_C1C1C1C1_00000001;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request from a negedge, drops it on the pulse cycle and returns
  // the latency in edges from acceptance (-1 if no pulse in the budget).
  task automatic xact(input bit is_wr, input bit both, input logic [5:0] addr,
                      input logic [127:0] din, output int lat);
    bus.memWen    = is_wr | both;
    bus.memRen    = ~is_wr | both;
    bus.BlockAddr = addr;
    bus.memDin    = din;
    lat = -1;
    @(negedge clock);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if ((is_wr ? bus.memWriteDone : bus.memReadReady) === 1'b1) begin
        lat = k;
        break;
      end
    end
    bus.memWen = 1'b0;
    bus.memRen = 1'b0;
  endtask

  initial begin
    int lat, wlat, rlat, seen;
    bus.memRen = 1'b0;  bus.memWen = 1'b0;  bus.BlockAddr = '0;  bus.memDin = '0;
    bus1.memRen = 1'b0; bus1.memWen = 1'b0; bus1.BlockAddr = '0; bus1.memDin = '0;

    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_ready", 128'(bus.memReadReady), 128'(0));
    check("rst_done",  128'(bus.memWriteDone), 128'(0));
    check("rst_dout",  bus.memDout, 128'(0));
    check("rst_perr",  128'(bus.protocolError), 128'(0));

    // Preload blocks used later.
    xact(1, 0, 6'd5, V5, lat);  check("wr5_lat", 128'(lat), 128'(4)); @(negedge clock);
    xact(1, 0, 6'd7, V7, lat);  @(negedge clock);
    xact(1, 0, 6'd9, V9, lat);  @(negedge clock);
    check("wr_dout_untouched", bus.memDout, 128'(0));

    // Basic read of block 5.
    xact(0, 0, 6'd5, '0, lat);
    check("rd5_lat",  128'(lat), 128'(4));
    check("rd5_dout", bus.memDout, V5);
    @(negedge clock);
    check("rd5_pulse_once", 128'(bus.memReadReady), 128'(0));
    check("rd5_dout_held",  bus.memDout, V5);

    // Write block 3 while scrambling address/data during the wait.
    bus.memWen = 1'b1; bus.BlockAddr = 6'd3; bus.memDin = DEAD;
    @(negedge clock);
    bus.BlockAddr = 6'd7; bus.memDin = '0;
    seen = 0; lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (bus.memWriteDone === 1'b1) begin seen++; if (lat < 0) lat = k; bus.memWen = 1'b0; end
    end
    check("wr3_lat",   128'(lat), 128'(4));
    check("wr3_count", 128'(seen), 128'(1));
    check("wr3_dout_held", bus.memDout, V5);
    xact(0, 0, 6'd3, '0, lat); check("rd3_dout", bus.memDout, DEAD); @(negedge clock);
    xact(0, 0, 6'd7, '0, lat); check("rd7_dout", bus.memDout, V7);   @(negedge clock);

    // Writeback then fill of the same block, as the controller sequences it.
    xact(1, 0, 6'd10, WB, wlat);
    @(negedge clock);
    xact(0, 0, 6'd10, '0, rlat);
    check("wbf_total", 128'(wlat + 2 + rlat), 128'(10));
    check("wbf_fill_lat", 128'(rlat), 128'(4));
    check("wbf_dout", bus.memDout, WB);
    @(negedge clock);

    // Read and write together: write wins, error flag sticks.
    xact(1, 1, 6'd12, C12, lat);
    check("both_lat",   128'(lat), 128'(4));
    check("both_noread", 128'(bus.memReadReady), 128'(0));
    check("both_perr",  128'(bus.protocolError), 128'(1));
    @(negedge clock);
    xact(0, 0, 6'd12, '0, lat); check("both_rd12", bus.memDout, C12); @(negedge clock);
    xact(1, 0, 6'd13, V7, lat); @(negedge clock);
    check("perr_sticky", 128'(bus.protocolError), 128'(1));

    // Reset two cycles into a write of block 9 aborts it.
    bus.memWen = 1'b1; bus.BlockAddr = 6'd9; bus.memDin = N9;
    seen = 0;
    @(negedge clock); seen += int'(bus.memWriteDone);
    @(negedge clock); seen += int'(bus.memWriteDone);
    reset = 1'b1; bus.memWen = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    check("abort_ready", 128'(bus.memReadReady), 128'(0));
    check("abort_done",  128'(bus.memWriteDone), 128'(0));
    check("abort_dout",  bus.memDout, 128'(0));
    check("abort_perr",  128'(bus.protocolError), 128'(0));
    repeat (6) begin @(negedge clock); seen += int'(bus.memWriteDone); end
    check("abort_nopulse", 128'(seen), 128'(0));
    xact(0, 0, 6'd9, '0, lat); check("abort_rd9", bus.memDout, V9); @(negedge clock);

    // Latency-1 instance: request held high across two full transactions.
    bus1.memWen = 1'b1; bus1.BlockAddr = 6'd1; bus1.memDin = C1;
    @(negedge clock); check("l1_acc",   128'(bus1.memWriteDone), 128'(0));
    @(negedge clock); check("l1_pulse", 128'(bus1.memWriteDone), 128'(1));
    @(negedge clock); check("l1_done",  128'(bus1.memWriteDone), 128'(0));
    @(negedge clock); check("l1_reacc", 128'(bus1.memWriteDone), 128'(0));
    @(negedge clock); check("l1_pulse2", 128'(bus1.memWriteDone), 128'(1));
    bus1.memWen = 1'b0;
    @(negedge clock); check("l1_clear", 128'(bus1.memWriteDone), 128'(0));
    bus1.memRen = 1'b1;
    @(negedge clock); check("l1_rd_acc",  128'(bus1.memReadReady), 128'(0));
    @(negedge clock); check("l1_rd_pulse", 128'(bus1.memReadReady), 128'(1));
    check("l1_rd_dout", bus1.memDout, C1);
    bus1.memRen = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
